axilite2axi_pipe: RTL and testbench

Parametrised AXI-lite slave to AXI4 master bridge. It is the pipelined successor to the combinational pass-through bridge. Every channel can have an optional registered skid buffer. Outstanding reads and writes are counted per direction and throttled at a programmable limit. All AXI4 sideband fields are driven to protocol-correct constants. It sits between AXI-lite masters (CPU buses, Wishbone-to-AXI-lite bridges) and AXI4 interconnect or slave ports.

---
 rtl/axilite2axi_pipe_if.sv | 98 +++++++++
 rtl/axilite2axi_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_axilite2axi_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axilite2axi_pipe_if.sv
// Bus bundles for the AXI-lite to AXI4 bridge: the AXI-lite upstream port
// and the single-beat AXI4 downstream port, each with master/slave views.

interface axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface axi4_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
               wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
               rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
               wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
               rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axilite2axi_pipe.sv
// Pipelined AXI-lite slave to AXI4 master bridge with per-channel skid buffers
// and per-direction outstanding-transaction throttling.

module axilite2axi_pipe_skid #(
    parameter int W       = 8,
    parameter bit OPT_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    generate
        if (OPT_REG) begin : g_reg
            logic         out_valid_r;
            logic         skid_valid_r;
            logic [W-1:0] out_data_r;
            logic [W-1:0] skid_data_r;
            logic         in_hs_s;
            logic         out_free_s;

            // The skid slot only fills while the output is stalled, so upstream
            // ready can be a plain register-derived signal.
            assign in_ready   = !skid_valid_r;
            assign in_hs_s    = in_valid && !skid_valid_r;
            assign out_free_s = !out_valid_r || out_ready;
            assign out_valid  = out_valid_r;
            assign out_data   = out_data_r;

            // Occupancy flags for the output and skid slots
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_r  <= 1'b0;
                    skid_valid_r <= 1'b0;
                end else if (out_free_s) begin
                    out_valid_r  <= skid_valid_r || in_hs_s;
                    skid_valid_r <= 1'b0;
                end else begin
                    out_valid_r  <= out_valid_r;
                    skid_valid_r <= skid_valid_r || in_hs_s;
                end
            end

            // Payload movement: skid drains first so ordering is preserved
            always_ff @(posedge clk) begin
                if (out_free_s) begin
                    if (skid_valid_r) begin
                        out_data_r <= skid_data_r;
                    end else if (in_hs_s) begin
                        out_data_r <= in_data;
                    end else begin
                        out_data_r <= out_data_r;
                    end
                end else if (in_hs_s) begin
                    skid_data_r <= in_data;
                end else begin
                    skid_data_r <= skid_data_r;
                end
            end
        end else begin : g_pass
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign out_data  = in_data;
        end
    endgenerate
endmodule

module axilite2axi_pipe #(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_WRITE_ID   = 0,
    parameter int C_AXI_READ_ID    = 0,
    parameter int LGMAXOUT         = 4,
    parameter int OPT_REGISTERED   = 1
) (
    input  logic                ACLK,
    input  logic                ARESET,
    axil_if.slave               s_axi,
    axi4_if.master              m_axi,
    output logic [LGMAXOUT-1:0] o_wr_count,
    output logic [LGMAXOUT-1:0] o_rd_count
);
    localparam int                  STRB_W    = C_AXI_DATA_WIDTH / 8;
    localparam int                  AX_W      = C_AXI_ADDR_WIDTH + 3;
    localparam int                  WD_W      = C_AXI_DATA_WIDTH + STRB_W;
    localparam int                  RD_W      = C_AXI_DATA_WIDTH + 2;
    localparam bit                  OPT_REG_C = (OPT_REGISTERED != 0);
    localparam logic [2:0]          AXSIZE_C  = 3'($clog2(C_AXI_DATA_WIDTH) - 3);
    localparam logic [LGMAXOUT-1:0] ZERO_C    = {LGMAXOUT{1'b0}};
    localparam logic [LGMAXOUT-1:0] ONE_C     = LGMAXOUT'(1'b1);
    localparam logic [LGMAXOUT-1:0] MAX_OUT_C = {LGMAXOUT{1'b1}};

    logic [LGMAXOUT-1:0] wr_count_r;
    logic [LGMAXOUT-1:0] rd_count_r;
    logic                wr_full_s;
    logic                rd_full_s;
    logic                aw_ready_s;
    logic                ar_ready_s;
    logic                aw_hs_s;
    logic                b_hs_s;
    logic                ar_hs_s;
    logic                r_hs_s;
    logic [AX_W-1:0]     aw_out_s;
    logic [WD_W-1:0]     w_out_s;
    logic [AX_W-1:0]     ar_out_s;
    logic [RD_W-1:0]     r_out_s;

    // Throttle on the registered count, so READY drops the cycle after the limit is hit
    assign wr_full_s = (wr_count_r == MAX_OUT_C);
    assign rd_full_s = (rd_count_r == MAX_OUT_C);

    assign s_axi.awready = aw_ready_s && !wr_full_s;
    assign s_axi.arready = ar_ready_s && !rd_full_s;

    assign aw_hs_s = s_axi.awvalid && s_axi.awready;
    assign b_hs_s  = s_axi.bvalid  && s_axi.bready;
    assign ar_hs_s = s_axi.arvalid && s_axi.arready;
    assign r_hs_s  = s_axi.rvalid  && s_axi.rready;

    axilite2axi_pipe_skid #(.W(AX_W), .OPT_REG(OPT_REG_C)) u_aw (
        .clk(ACLK), .rst(ARESET),
        .in_valid(s_axi.awvalid && !wr_full_s), .in_ready(aw_ready_s),
        .in_data({s_axi.awaddr, s_axi.awprot}),
        .out_valid(m_axi.awvalid), .out_ready(m_axi.awready), .out_data(aw_out_s)
    );

    axilite2axi_pipe_skid #(.W(WD_W), .OPT_REG(OPT_REG_C)) u_w (
        .clk(ACLK), .rst(ARESET),
        .in_valid(s_axi.wvalid), .in_ready(s_axi.wready),
        .in_data({s_axi.wdata, s_axi.wstrb}),
        .out_valid(m_axi.wvalid), .out_ready(m_axi.wready), .out_data(w_out_s)
    );

    axilite2axi_pipe_skid #(.W(2), .OPT_REG(OPT_REG_C)) u_b (
        .clk(ACLK), .rst(ARESET),
        .in_valid(m_axi.bvalid), .in_ready(m_axi.bready), .in_data(m_axi.bresp),
        .out_valid(s_axi.bvalid), .out_ready(s_axi.bready), .out_data(s_axi.bresp)
    );

    axilite2axi_pipe_skid #(.W(AX_W), .OPT_REG(OPT_REG_C)) u_ar (
        .clk(ACLK), .rst(ARESET),
        .in_valid(s_axi.arvalid && !rd_full_s), .in_ready(ar_ready_s),
        .in_data({s_axi.araddr, s_axi.arprot}),
        .out_valid(m_axi.arvalid), .out_ready(m_axi.arready), .out_data(ar_out_s)
    );

    axilite2axi_pipe_skid #(.W(RD_W), .OPT_REG(OPT_REG_C)) u_r (
        .clk(ACLK), .rst(ARESET),
        .in_valid(m_axi.rvalid), .in_ready(m_axi.rready),
        .in_data({m_axi.rdata, m_axi.rresp}),
        .out_valid(s_axi.rvalid), .out_ready(s_axi.rready), .out_data(r_out_s)
    );

    assign {m_axi.awaddr, m_axi.awprot} = aw_out_s;
    assign {m_axi.wdata, m_axi.wstrb}   = w_out_s;
    assign {m_axi.araddr, m_axi.arprot} = ar_out_s;
    assign {s_axi.rdata, s_axi.rresp}   = r_out_s;

    // Every transfer is a single INCR beat of full bus width
    assign m_axi.awid    = C_AXI_ID_WIDTH'(C_AXI_WRITE_ID);
    assign m_axi.awlen   = 8'h00;
    assign m_axi.awsize  = AXSIZE_C;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awqos   = 4'h0;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.arid    = C_AXI_ID_WIDTH'(C_AXI_READ_ID);
    assign m_axi.arlen   = 8'h00;
    assign m_axi.arsize  = AXSIZE_C;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arqos   = 4'h0;

    // Outstanding-write count; saturates at both ends instead of wrapping
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_count_r <= ZERO_C;
        end else if (aw_hs_s && !b_hs_s && !wr_full_s) begin
            wr_count_r <= wr_count_r + ONE_C;
        end else if (b_hs_s && !aw_hs_s && (wr_count_r != ZERO_C)) begin
            wr_count_r <= wr_count_r - ONE_C;
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    // Outstanding-read count; saturates at both ends instead of wrapping
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_count_r <= ZERO_C;
        end else if (ar_hs_s && !r_hs_s && !rd_full_s) begin
            rd_count_r <= rd_count_r + ONE_C;
        end else if (r_hs_s && !ar_hs_s && (rd_count_r != ZERO_C)) begin
            rd_count_r <= rd_count_r - ONE_C;
        end else begin
            rd_count_r <= rd_count_r;
        end
    end

    assign o_wr_count = wr_count_r;
    assign o_rd_count = rd_count_r;
endmodule

// File: tb/tb_axilite2axi_pipe.sv
// Randomised scoreboard bench for axilite2axi_pipe (registered mode, LGMAXOUT=2).

module tb_axilite2axi_pipe;
    localparam int IDW  = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LGM  = 2;
    localparam int MAXO = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();
    axi4_if #(.ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) m_if ();
    logic [LGM-1:0] wr_cnt;
    logic [LGM-1:0] rd_cnt;

    axilite2axi_pipe #(
        .C_AXI_ID_WIDTH(IDW), .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW),
        .C_AXI_WRITE_ID(5), .C_AXI_READ_ID(9), .LGMAXOUT(LGM), .OPT_REGISTERED(1)
    ) dut (
        .ACLK(clk), .ARESET(rst), .s_axi(s_if), .m_axi(m_if),
        .o_wr_count(wr_cnt), .o_rd_count(rd_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [34:0] src_aw[$], src_ar[$], exp_aw[$], exp_ar[$];
    logic [35:0] src_w[$], exp_w[$];
    logic [1:0]  slv_b[$], exp_b[$], exp_rresp[$];
    logic [33:0] slv_r[$];
    logic [31:0] exp_raddr[$];
    int slv_aw_n, slv_w_n, slv_b_made, wr_out, rd_out, aw_acc, b_done, r_done, rd_peak;
    bit lat_aw, lat_w, lat_ar, lat_b, lat_r, aw_stall, ar_stall;
    logic [34:0] aw_stall_v, ar_stall_v;
    logic [1:0] last_bresp, last_rresp;
    int s_rate, m_rate, rsp_rate;
    bit b_en, r_en, resp_rand;
    logic [1:0] bresp_fix, rresp_fix;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave read data is a fixed scramble of the address, so R data is checked end to end
    function automatic logic [31:0] rd_data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    function automatic logic [1:0] pick_resp(input logic [1:0] fix);
        return resp_rand ? 2'($urandom_range(3)) : fix;
    endfunction

    task automatic add_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        src_aw.push_back({a, 3'($urandom_range(7))});
        src_w.push_back({d, s});
    endtask

    task automatic add_read(input logic [31:0] a);
        src_ar.push_back({a, 3'($urandom_range(7))});
    endtask

    task automatic clear_model();
        src_aw.delete(); src_ar.delete(); exp_aw.delete(); exp_ar.delete();
        src_w.delete(); exp_w.delete(); slv_b.delete(); exp_b.delete();
        exp_rresp.delete(); slv_r.delete(); exp_raddr.delete();
        slv_aw_n = 0; slv_w_n = 0; slv_b_made = 0; wr_out = 0; rd_out = 0;
        lat_aw = 0; lat_w = 0; lat_ar = 0; lat_b = 0; lat_r = 0;
        aw_stall = 0; ar_stall = 0;
    endtask

    // One clock: sample and score at the falling edge, drive just after the rising edge
    task automatic step();
        bit s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
        bit m_aw_hs, m_w_hs, m_b_hs, m_ar_hs, m_r_hs;
        @(negedge clk);
        if (lat_aw) check_val("aw_latency", m_if.awvalid, 1);
        if (lat_w)  check_val("w_latency",  m_if.wvalid,  1);
        if (lat_ar) check_val("ar_latency", m_if.arvalid, 1);
        if (lat_b)  check_val("b_latency",  s_if.bvalid,  1);
        if (lat_r)  check_val("r_latency",  s_if.rvalid,  1);
        check_val("wr_count", wr_cnt, wr_out);
        check_val("rd_count", rd_cnt, rd_out);
        if (wr_out == MAXO) check_val("awready_at_max", s_if.awready, 0);
        if (rd_out == MAXO) check_val("arready_at_max", s_if.arready, 0);
        if (int'(rd_cnt) > rd_peak) rd_peak = int'(rd_cnt);
        if (aw_stall) begin
            check_val("aw_hold_valid", m_if.awvalid, 1);
            check_val("aw_hold_addr", {m_if.awaddr, m_if.awprot}, aw_stall_v);
        end
        if (ar_stall) begin
            check_val("ar_hold_valid", m_if.arvalid, 1);
            check_val("ar_hold_addr", {m_if.araddr, m_if.arprot}, ar_stall_v);
        end
        aw_stall = m_if.awvalid && !m_if.awready;
        aw_stall_v = {m_if.awaddr, m_if.awprot};
        ar_stall = m_if.arvalid && !m_if.arready;
        ar_stall_v = {m_if.araddr, m_if.arprot};

        s_aw_hs = s_if.awvalid && s_if.awready;
        s_w_hs  = s_if.wvalid  && s_if.wready;
        s_b_hs  = s_if.bvalid  && s_if.bready;
        s_ar_hs = s_if.arvalid && s_if.arready;
        s_r_hs  = s_if.rvalid  && s_if.rready;
        m_aw_hs = m_if.awvalid && m_if.awready;
        m_w_hs  = m_if.wvalid  && m_if.wready;
        m_b_hs  = m_if.bvalid  && m_if.bready;
        m_ar_hs = m_if.arvalid && m_if.arready;
        m_r_hs  = m_if.rvalid  && m_if.rready;
        lat_aw = s_aw_hs; lat_w = s_w_hs; lat_ar = s_ar_hs; lat_b = m_b_hs; lat_r = m_r_hs;

        if (s_aw_hs) begin
            exp_aw.push_back({s_if.awaddr, s_if.awprot});
            void'(src_aw.pop_front());
            wr_out++; aw_acc++;
        end
        if (s_w_hs) begin
            exp_w.push_back({s_if.wdata, s_if.wstrb});
            void'(src_w.pop_front());
        end
        if (s_ar_hs) begin
            exp_ar.push_back({s_if.araddr, s_if.arprot});
            exp_raddr.push_back(s_if.araddr);
            void'(src_ar.pop_front());
            rd_out++;
        end
        if (m_aw_hs) begin
            check_val("aw_expected", exp_aw.size() > 0, 1);
            if (exp_aw.size() > 0) check_val("aw_payload", {m_if.awaddr, m_if.awprot}, exp_aw.pop_front());
            check_val("aw_fields", {m_if.awid, m_if.awlen, m_if.awsize, m_if.awburst, m_if.awlock, m_if.awcache, m_if.awqos},
                      {4'd5, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 4'd0});
            slv_aw_n++;
        end
        if (m_w_hs) begin
            check_val("w_expected", exp_w.size() > 0, 1);
            if (exp_w.size() > 0) check_val("w_payload", {m_if.wdata, m_if.wstrb}, exp_w.pop_front());
            check_val("wlast", m_if.wlast, 1);
            slv_w_n++;
        end
        while (slv_b_made < ((slv_aw_n < slv_w_n) ? slv_aw_n : slv_w_n)) begin
            slv_b.push_back(pick_resp(bresp_fix));
            slv_b_made++;
        end
        if (m_b_hs) begin
            exp_b.push_back(m_if.bresp);
            void'(slv_b.pop_front());
        end
        if (s_b_hs) begin
            check_val("b_expected", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) check_val("b_resp", s_if.bresp, exp_b.pop_front());
            last_bresp = s_if.bresp;
            wr_out--; b_done++;
        end
        if (m_ar_hs) begin
            check_val("ar_expected", exp_ar.size() > 0, 1);
            if (exp_ar.size() > 0) check_val("ar_payload", {m_if.araddr, m_if.arprot}, exp_ar.pop_front());
            check_val("ar_fields", {m_if.arid, m_if.arlen, m_if.arsize, m_if.arburst, m_if.arlock, m_if.arcache, m_if.arqos},
                      {4'd9, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 4'd0});
            slv_r.push_back({rd_data_of(m_if.araddr), pick_resp(rresp_fix)});
        end
        if (m_r_hs) begin
            exp_rresp.push_back(m_if.rresp);
            void'(slv_r.pop_front());
        end
        if (s_r_hs) begin
            check_val("r_expected", exp_raddr.size() > 0, 1);
            if (exp_raddr.size() > 0) check_val("r_data", s_if.rdata, rd_data_of(exp_raddr.pop_front()));
            if (exp_rresp.size() > 0) check_val("r_resp", s_if.rresp, exp_rresp.pop_front());
            last_rresp = s_if.rresp;
            rd_out--; r_done++;
        end

        @(posedge clk);
        #1;
        if (!(s_if.awvalid && !s_aw_hs)) begin
            if (src_aw.size() > 0 && roll(s_rate)) begin
                s_if.awvalid = 1'b1;
                {s_if.awaddr, s_if.awprot} = src_aw[0];
            end else s_if.awvalid = 1'b0;
        end
        if (!(s_if.wvalid && !s_w_hs)) begin
            if (src_w.size() > 0 && roll(s_rate)) begin
                s_if.wvalid = 1'b1;
                {s_if.wdata, s_if.wstrb} = src_w[0];
            end else s_if.wvalid = 1'b0;
        end
        if (!(s_if.arvalid && !s_ar_hs)) begin
            if (src_ar.size() > 0 && roll(s_rate)) begin
                s_if.arvalid = 1'b1;
                {s_if.araddr, s_if.arprot} = src_ar[0];
            end else s_if.arvalid = 1'b0;
        end
        s_if.bready  = roll(rsp_rate);
        s_if.rready  = roll(rsp_rate);
        m_if.awready = roll(m_rate);
        m_if.wready  = roll(m_rate);
        m_if.arready = roll(m_rate);
        if (!(m_if.bvalid && !m_b_hs)) begin
            if (b_en && slv_b.size() > 0 && roll(m_rate)) begin
                m_if.bvalid = 1'b1;
                m_if.bresp  = slv_b[0];
                m_if.bid    = 4'($urandom_range(15));
            end else m_if.bvalid = 1'b0;
        end
        if (!(m_if.rvalid && !m_r_hs)) begin
            if (r_en && slv_r.size() > 0 && roll(m_rate)) begin
                m_if.rvalid = 1'b1;
                {m_if.rdata, m_if.rresp} = slv_r[0];
                m_if.rid    = 4'($urandom_range(15));
            end else m_if.rvalid = 1'b0;
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
        m_if.bvalid = 1'b0; m_if.rvalid = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val({tag, "_valids"}, {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}, 5'b00000);
        check_val({tag, "_wr_count"}, wr_cnt, 0);
        check_val({tag, "_rd_count"}, rd_cnt, 0);
        check_val({tag, "_readies"}, {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}, 5'b11111);
    endtask

    initial begin
        int base_aw, base_b, base_r;
        s_if.awaddr = '0; s_if.awprot = '0; s_if.awvalid = 1'b0;
        s_if.wdata = '0; s_if.wstrb = '0; s_if.wvalid = 1'b0;
        s_if.bready = 1'b0; s_if.araddr = '0; s_if.arprot = '0; s_if.arvalid = 1'b0; s_if.rready = 1'b0;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
        m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 1'b0;
        m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 1'b0;
        s_rate = 100; m_rate = 100; rsp_rate = 100; b_en = 1; r_en = 1; resp_rand = 0;
        bresp_fix = 2'b00; rresp_fix = 2'b00; aw_acc = 0; b_done = 0; r_done = 0; rd_peak = 0;
        last_bresp = 2'b00; last_rresp = 2'b00;
        do_reset("reset");

        // Single write
        src_aw.push_back({32'h0000_0100, 3'b000});
        src_w.push_back({32'hDEAD_BEEF, 4'hF});
        for (int c = 0; c < 50 && b_done < 1; c++) step();
        check_val("single_wr_done", b_done, 1);
        check_val("single_wr_bresp", last_bresp, 2'b00);

        // Eight back-to-back reads
        base_r = r_done; rd_peak = 0;
        for (int i = 0; i < 8; i++) add_read(32'h0000_1000 + 32'(4 * i));
        for (int c = 0; c < 100 && r_done < base_r + 8; c++) step();
        check_val("b2b_reads_done", r_done - base_r, 8);
        check_val("b2b_rd_peak_ok", rd_peak <= 8, 1);
        step();
        check_val("b2b_rd_idle", rd_cnt, 0);

        // Throttle at 2^LGM-1 outstanding writes
        b_en = 0; base_aw = aw_acc; base_b = b_done;
        for (int i = 0; i < 4; i++) add_write(32'h0000_2000 + 32'(4 * i), $urandom, 4'hF);
        for (int c = 0; c < 15; c++) step();
        check_val("thr_accepted", aw_acc - base_aw, 3);
        check_val("thr_wr_count", wr_cnt, 3);
        check_val("thr_awready", s_if.awready, 0);
        b_en = 1;
        for (int c = 0; c < 50 && aw_acc - base_aw < 4; c++) step();
        check_val("thr_fourth_aw", aw_acc - base_aw, 4);
        for (int c = 0; c < 50 && b_done - base_b < 4; c++) step();
        check_val("thr_all_b", b_done - base_b, 4);

        // Random backpressure on every channel
        s_rate = 70; m_rate = 50; rsp_rate = 60; resp_rand = 1;
        base_r = r_done; base_b = b_done;
        for (int i = 0; i < 200; i++) add_read($urandom);
        for (int i = 0; i < 60; i++) add_write($urandom, $urandom, 4'($urandom_range(15)));
        for (int c = 0; c < 6000 && (r_done - base_r < 200 || b_done - base_b < 60); c++) step();
        check_val("bp_reads_done", r_done - base_r, 200);
        check_val("bp_writes_done", b_done - base_b, 60);
        check_val("bp_queues_empty", exp_aw.size() + exp_ar.size() + exp_w.size() + exp_raddr.size(), 0);

        // Error responses pass straight through
        s_rate = 100; m_rate = 100; rsp_rate = 100; resp_rand = 0;
        bresp_fix = 2'b11; rresp_fix = 2'b10;
        base_r = r_done; base_b = b_done;
        for (int i = 0; i < 2; i++) begin
            add_read(32'h0000_3000 + 32'(4 * i));
            add_write(32'h0000_3100 + 32'(4 * i), $urandom, 4'h3);
        end
        for (int c = 0; c < 60 && (r_done - base_r < 2 || b_done - base_b < 2); c++) step();
        check_val("slverr_count", (r_done - base_r) + (b_done - base_b), 4);
        check_val("slverr_rresp", last_rresp, 2'b10);
        check_val("slverr_bresp", last_bresp, 2'b11);

        // Reset with traffic in flight
        bresp_fix = 2'b00; rresp_fix = 2'b00; b_en = 0; r_en = 0;
        for (int i = 0; i < 2; i++) begin
            add_read(32'h0000_4000 + 32'(4 * i));
            add_write(32'h0000_4100 + 32'(4 * i), $urandom, 4'hF);
        end
        for (int c = 0; c < 40 && (wr_out < 2 || rd_out < 2); c++) step();
        check_val("midrst_wr_pending", wr_out, 2);
        check_val("midrst_rd_pending", rd_out, 2);
        do_reset("midrst");
        b_en = 1; r_en = 1; base_b = b_done;
        add_write(32'h0000_5000, 32'h1234_5678, 4'hF);
        for (int c = 0; c < 50 && b_done - base_b < 1; c++) step();
        check_val("post_rst_write", b_done - base_b, 1);
        step();
        check_val("post_rst_idle", wr_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
